hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Producer end of the HI/LO path. The execute stage only reads HI/LO; this block owns and writes them.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from execute.
- Holds the architectural HI and LO registers and raises busy so the pipeline stalls on HI/LO readers and further mul/div issue.
- Pipeline-stage forwarding of HI/LO stays outside this block.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.
- DIV_BITS_PER_CYCLE, 1, quotient bits per iteration cycle; legal values 1 or 2. Iteration count N = WIDTH/DIV_BITS_PER_CYCLE.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- start  in  1  issue valid, sampled at rising edge of clk
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 see Optional Feature
- a  in  32  rs operand (dividend / multiplicand / MTxx source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  nullify in-flight operation
- busy  out  1  operation in progress; execute stalls HI/LO consumers and new issue
- done  out  1  one-cycle pulse after HI/LO written by a mul/div
- hi  out  32  architectural HI (registered)
- lo  out  32  architectural LO (registered)

Behaviour:
- Reset (synchronous, active-high, dominant over all inputs): hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0.
- States:
  - IDLE
  - MUL: 1 cycle
  - DIV: N iteration cycles
  - FIX: 1 cycle
- busy = (state != IDLE), decoded from state, no extra register.
- Issue: start is accepted only in IDLE. Any start while busy=1 is ignored; the pipeline guarantees it does not occur, and the bench checks that it is ignored.
- MTHI/MTLO: the edge that samples start writes hi (or lo) = a. State stays IDLE, done stays 0, the other register is unchanged.
- MULT/MULTU:
  - Edge ending cycle T latches a, b and signedness; state goes to MUL.
  - Edge ending T+1 writes {hi,lo} = 64-bit product (signed or unsigned); state goes to IDLE.
  - done=1 during T+2. busy=1 during T+1 only.
- DIV/DIVU:
  - Edge ending T latches |a|, |b| (absolute values for DIV, raw values for DIVU) and the result signs; state goes to DIV.
  - Restoring shift-subtract for N cycles, then FIX for 1 cycle.
  - FIX applies signs: quotient negative iff signs differ; remainder takes the dividend's sign.
  - Edge ending FIX writes lo=quotient, hi=remainder.
  - With N=32, busy=1 during T+1..T+33 and done=1 during T+34.
- Divide by zero (b=0): same latency; result is hi=a, lo=32'hFFFF_FFFF for both DIV and DIVU.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- flush: at the next edge, state goes to IDLE, done=0, and hi/lo keep their pre-operation values. flush and start in the same cycle: flush wins, nothing issues. flush in IDLE has no effect. A flush in the same cycle as the write edge (MUL cycle or FIX) suppresses the write.
- Reset mid-operation clears everything, including hi/lo.
- Width rules: the product is a full 64-bit result. Divider partial remainder is 33 bits. Negation is two's complement, and |0x80000000| = 0x80000000 unsigned.

Optional Feature:
- Macro: HILO_MULDIV_MADD_EN.
- Defined:
  - op 110 = MADD: {hi,lo} += signed a*b.
  - op 111 = MSUB: {hi,lo} -= signed a*b.
  - Both use the MUL state plus one ACC state, so busy is high for 2 cycles and done is high in T+3. Accumulation is a 64-bit wrap-around add/subtract.
- Undefined: op 110/111 are ignored; state stays IDLE, hi/lo unchanged, busy and done stay 0.

Test Plan:
- reset, then MTHI a=0x1234_5678, then MTLO a=0xCAFE_F00D -> hi=0x12345678, lo=0xCAFEF00D one edge after each issue; busy and done never assert.
- MULT a=0xFFFF_FFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done at T+2; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high exactly 33 cycles, done at T+34; DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF.
- DIV issued, flush at iteration 10 -> busy drops next edge, hi/lo keep prior values, no done; a second start during busy is ignored.
- With HILO_MULDIV_MADD_EN: hi=0, lo=10, then MADD 3*4 -> lo=22; then MSUB 5*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: MULT/MULTU/DIV/DIVU/MTHI/MTLO with a 1-cycle multiplier and a restoring divider.
// Optional MADD/MSUB accumulate ops are compiled in with `define HILO_MULDIV_MADD_EN.
module hilo_muldiv_unit #(
  parameter int WIDTH              = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / DIV_BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_ACC  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_quo;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic [2*WIDTH-1:0]     r_prod;
  logic                   r_signed;
  logic                   r_macc;
  logic                   r_msub;
  logic                   r_qneg;
  logic                   r_rneg;
  logic                   r_dvz;
  logic                   r_done;

  logic                   w_issue;
  logic                   w_op_mul;
  logic                   w_op_div;
  logic                   w_op_macc;
  logic                   w_div_signed;
  logic [2*WIDTH-1:0]     w_ext_a;
  logic [2*WIDTH-1:0]     w_ext_b;
  logic [2*WIDTH-1:0]     w_prod;
  logic [2*WIDTH-1:0]     w_hilo;
  logic [2*WIDTH-1:0]     w_step1;
  logic [2*WIDTH-1:0]     w_step;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    neg_val = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) abs_val = neg_val(v);
    else            abs_val = v;
  endfunction

  // One restoring step; the 33-bit trial difference's top bit flags "divisor did not fit".
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    else             div_step = {diff[WIDTH-1:0],    quo[WIDTH-2:0], 1'b1};
  endfunction

  assign w_issue      = (r_state == S_IDLE) && start && !flush;
  assign w_op_mul     = (op == OP_MULT) || (op == OP_MULTU);
  assign w_op_div     = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_div_signed = (op == OP_DIV);
`ifdef HILO_MULDIV_MADD_EN
  assign w_op_macc    = (op == OP_MADD) || (op == OP_MSUB);
`else
  assign w_op_macc    = 1'b0;
`endif

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are right either way.
  assign w_ext_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_hilo  = {r_hi, r_lo};

  assign w_step1 = div_step(r_rem, r_quo, r_b);
  generate
    if (DIV_BITS_PER_CYCLE == 2) begin : g_two_bits
      assign w_step = div_step(w_step1[2*WIDTH-1:WIDTH], w_step1[WIDTH-1:0], r_b);
    end else begin : g_one_bit
      assign w_step = w_step1;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; flush returns any busy state to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue && (w_op_mul || w_op_macc)) w_next_state = S_MUL;
        else if (w_issue && w_op_div)           w_next_state = S_DIV;
        else                                    w_next_state = S_IDLE;
      end
      S_MUL: begin
        if (flush)       w_next_state = S_IDLE;
        else if (r_macc) w_next_state = S_ACC;
        else             w_next_state = S_IDLE;
      end
      S_ACC:  w_next_state = S_IDLE;
      S_DIV: begin
        if (flush)                  w_next_state = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next_state = S_FIX;
        else                        w_next_state = S_DIV;
      end
      S_FIX:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, divider iteration and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_prod   <= {(2*WIDTH){1'b0}};
      r_signed <= 1'b0;
      r_macc   <= 1'b0;
      r_msub   <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dvz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            case (op)
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              OP_MULT, OP_MULTU: begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= (op == OP_MULT);
                r_macc   <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                r_a    <= a;
                r_b    <= w_div_signed ? abs_val(b) : b;
                r_quo  <= w_div_signed ? abs_val(a) : a;
                r_rem  <= {WIDTH{1'b0}};
                r_cnt  <= {CW{1'b0}};
                r_qneg <= w_div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_rneg <= w_div_signed & a[WIDTH-1];
                r_dvz  <= (b == {WIDTH{1'b0}});
              end
`ifdef HILO_MULDIV_MADD_EN
              OP_MADD, OP_MSUB: begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= 1'b1;
                r_macc   <= 1'b1;
                r_msub   <= (op == OP_MSUB);
              end
`endif
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!flush) begin
            if (r_macc) begin
              r_prod <= w_prod;
            end else begin
              {r_hi, r_lo} <= w_prod;
              r_done       <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (!flush) begin
            {r_hi, r_lo} <= r_msub ? (w_hilo - r_prod) : (w_hilo + r_prod);
            r_done       <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_step[2*WIDTH-1:WIDTH];
          r_quo <= w_step[WIDTH-1:0];
          r_cnt <= r_cnt + CNT_ONE;
        end
        S_FIX: begin
          if (!flush) begin
            if (r_dvz) begin
              r_hi <= r_a;
              r_lo <= {WIDTH{1'b1}};
            end else begin
              r_hi <= r_rneg ? neg_val(r_rem) : r_rem;
              r_lo <= r_qneg ? neg_val(r_quo) : r_quo;
            end
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (default build, N=32).
// Defining HILO_MULDIV_MADD_EN for both files exercises MADD/MSUB instead of the ignored-op check.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  hilo_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Drives one issue cycle; returns at the falling edge inside cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    reset = 1'b0;
    // reset in the middle of a divide also wipes HI/LO
    issue(OP_MTHI, 32'h0000_0055, 32'h0);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h expected 00000000", hi); end
    repeat (40) @(negedge clk);
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_mthi_mtlo;
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo: got %h expected 00000000", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0/0", busy, done); end
    issue(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo: got %h expected cafef00d", lo); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi: got %h expected 12345678", hi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_mult;
    logic [2:0]  ops [0:2];
    logic [31:0] va  [0:2];
    logic [31:0] vb  [0:2];
    logic [31:0] eh  [0:2];
    logic [31:0] el  [0:2];
    ops = '{OP_MULT, OP_MULTU, OP_MULT};
    va  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000};
    vb  = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0000};
    eh  = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h4000_0000};
    el  = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mul%0d_t1: got busy=%b done=%b expected 1/0", i, busy, done); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mul%0d_t2: got busy=%b done=%b expected 0/1", i, busy, done); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL mul%0d_hi: got %h expected %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL mul%0d_lo: got %h expected %h", i, lo, el[i]); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul%0d_done_pulse: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [0:6];
    logic [31:0] va  [0:6];
    logic [31:0] vb  [0:6];
    logic [31:0] eh  [0:6];
    logic [31:0] el  [0:6];
    int k;
    ops = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    va  = '{32'hFFFF_FFF9, 32'd100, 32'd7,         32'h8000_0000, 32'd5,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vb  = '{32'd2,         32'd7,   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,         32'd0,         32'h0000_0010};
    eh  = '{32'hFFFF_FFFF, 32'd2,   32'd1,         32'h0000_0000, 32'd5,         32'hFFFF_FFFB, 32'h0000_000F};
    el  = '{32'hFFFF_FFFD, 32'd14,  32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0FFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], va[i], vb[i]);
      k = 0;
      while (busy === 1'b1 && k < 100) begin
        k++;
        @(negedge clk);
      end
      checks++; if (k != 33) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d expected 33", i, k); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL div%0d_done: got %b expected 1", i, done); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, el[i]); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL div%0d_done_pulse: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_flush;
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    issue(OP_MTLO, 32'h0F0F_0F0F, 32'h0);
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; op = 3'b000; a = 32'h0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    checks++; if (hi !== 32'hAAAA_5555) begin errors++; $display("FAIL ignore_hi: got %h expected aaaa5555", hi); end
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_div_flags: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL flush_div_hilo: got %h_%h expected aaaa5555_0f0f0f0f", hi, lo); end
    repeat (40) @(negedge clk);
    checks++; if (done !== 1'b0 || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL flush_div_late: got done=%b lo=%h expected 0/0f0f0f0f", done, lo); end
    // flush and start together in IDLE: nothing issues
    start = 1'b1; op = OP_MTLO; a = 32'h0001_2345; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000; a = 32'h0; flush = 1'b0;
    checks++; if (lo !== 32'h0F0F_0F0F || busy !== 1'b0) begin errors++; $display("FAIL flush_start: got lo=%h busy=%b expected 0f0f0f0f/0", lo, busy); end
    // flush in the MUL write cycle
    issue(OP_MULTU, 32'd3, 32'd4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL flush_mul: got busy=%b done=%b lo=%h expected 0/0/0f0f0f0f", busy, done, lo); end
    // flush in the FIX write cycle
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy: got %b expected 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_fix_flags: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F) begin errors++; $display("FAIL flush_fix_hilo: got %h_%h expected aaaa5555_0f0f0f0f", hi, lo); end
  endtask

  task automatic test_back_to_back;
    issue(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    checks++; if (done !== 1'b1 || lo !== 32'd6) begin errors++; $display("FAIL b2b_first: got done=%b lo=%h expected 1/00000006", done, lo); end
    start = 1'b1; op = OP_MULTU; a = 32'd4; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || lo !== 32'd20 || hi !== 32'd0) begin errors++; $display("FAIL b2b_second: got done=%b hi=%h lo=%h expected 1/00000000/00000014", done, hi, lo); end
  endtask

`ifdef HILO_MULDIV_MADD_EN
  task automatic test_madd;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'd10, 32'h0);
    issue(OP_MADD, 32'd3, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL madd_t1: got busy=%b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL madd_t2: got busy=%b done=%b expected 1/0", busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL madd_t3: got busy=%b done=%b expected 0/1", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'd22) begin errors++; $display("FAIL madd_hilo: got %h_%h expected 00000000_00000016", hi, lo); end
    issue(OP_MSUB, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL msub_done: got %b expected 1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL msub_hilo: got %h_%h expected ffffffff_fffffffd", hi, lo); end
  endtask
`else
  task automatic test_madd_absent;
    issue(OP_MTHI, 32'h0000_1111, 32'h0);
    issue(OP_MTLO, 32'h0000_2222, 32'h0);
    issue(OP_MADD, 32'd3, 32'd4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy: got %b expected 0", busy); end
    issue(OP_MSUB, 32'd5, 32'd5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msub_off_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL madd_off_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0000_1111 || lo !== 32'h0000_2222) begin errors++; $display("FAIL madd_off_hilo: got %h_%h expected 00001111_00002222", hi, lo); end
  endtask
`endif

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mult;
    test_div;
    test_flush;
    test_back_to_back;
`ifdef HILO_MULDIV_MADD_EN
    test_madd;
`else
    test_madd_absent;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
